regfile_writer: RTL and testbench

- Write-side companion to the 32x32 register file read block, which has two 5-bit read addresses and two 32-bit read outputs.
- Accepts register write requests over a valid/ready handshake and buffers them in a small in-order queue.
- Drains one entry per cycle into the register file write port and honours a stall from the file.
- Provides two forwarding lookups so that reads to registers with pending queued writes return the youngest queued value.

---
 rtl/regfile_writer.sv | 135 +++++++++++++
 tb/tb_regfile_writer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writer.sv
// regfile_writer
// Write-side companion to a 32x32 register file. Write requests arrive on a
// valid/ready handshake and are held in a small in-order queue. One queued
// entry per cycle is drained into the register file write port unless the
// file stalls. Two combinational lookups return the youngest queued data for
// a register so reads can see writes that have not yet landed.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            request handshake
//   in_addr, in_data             destination register and data
//   wr_en, wr_addr, wr_data      register file write port (head entry)
//   wr_stall                     register file busy; head entry is held
//   inp1/inp2                    lookup addresses
//   hit1/hit2, fwd1/fwd2         lookup hit flags and youngest pending data
//   count                        number of occupied queue entries
module regfile_writer #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    output logic                     wr_en,
    output logic [AW-1:0]            wr_addr,
    output logic [DW-1:0]            wr_data,
    input  logic                     wr_stall,
    input  logic [AW-1:0]            inp1,
    input  logic [AW-1:0]            inp2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [DW-1:0]            fwd1,
    output logic [DW-1:0]            fwd2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head_reg;
    logic [PW-1:0]    tail_reg;
    logic [CW-1:0]    count_reg;
    logic [DEPTH-1:0] valid_reg;
    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];

    logic not_empty;
    logic accept;
    logic push;
    logic pop;

    assign not_empty = (count_reg != '0);
    // Ready looks only at the registered count, never at a same-cycle drain.
    assign in_ready  = (count_reg != CW'(DEPTH));
    assign accept    = in_valid && in_ready;
    // Register 0 is hardwired zero: the handshake completes but nothing is stored.
    assign push      = accept && (in_addr != '0);
    // Gating with rst guarantees no write escapes while pending entries are flushed.
    assign wr_en     = not_empty && !wr_stall && !rst;
    assign pop       = wr_en;
    assign wr_addr   = not_empty ? addr_mem[head_reg] : '0;
    assign wr_data   = not_empty ? data_mem[head_reg] : '0;
    assign count     = count_reg;

    // Control state: pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            valid_reg <= '0;
        end else begin
            if (push) begin
                valid_reg[tail_reg] <= 1'b1;
                tail_reg            <= tail_reg + PW'(1);
            end
            if (pop) begin
                valid_reg[head_reg] <= 1'b0;
                head_reg            <= head_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Entry storage needs no reset; the valid bits qualify every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_reg] <= in_addr;
            data_mem[tail_reg] <= in_data;
        end
    end

    // Per-entry address matches for both lookup ports.
    logic [DEPTH-1:0] match1;
    logic [DEPTH-1:0] match2;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match1[gi] = valid_reg[gi] && (addr_mem[gi] == inp1) && (inp1 != '0);
            assign match2[gi] = valid_reg[gi] && (addr_mem[gi] == inp2) && (inp2 != '0);
        end
    endgenerate

    // Walk entries oldest (head) to youngest; a later match overrides an
    // earlier one, so the entry closest to the tail wins.
    logic [PW-1:0] scan_idx;

    always_comb begin
        hit1     = 1'b0;
        hit2     = 1'b0;
        fwd1     = '0;
        fwd2     = '0;
        scan_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_reg + PW'(k);
            if (match1[scan_idx]) begin
                hit1 = 1'b1;
                fwd1 = data_mem[scan_idx];
            end
            if (match2[scan_idx]) begin
                hit2 = 1'b1;
                fwd2 = data_mem[scan_idx];
            end
        end
    end

endmodule

// File: tb/tb_regfile_writer.sv
// Testbench for regfile_writer: directed stimulus, expected writes pushed
// into a scoreboard queue and checked by an independent monitor.
module tb_regfile_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_stall;
    logic [4:0]  inp1;
    logic [4:0]  inp2;
    logic        hit1;
    logic        hit2;
    logic [31:0] fwd1;
    logic [31:0] fwd2;
    logic [2:0]  count;

    regfile_writer #(.DEPTH(4), .AW(5), .DW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_stall (wr_stall),
        .inp1     (inp1),
        .inp2     (inp2),
        .hit1     (hit1),
        .hit2     (hit2),
        .fwd1     (fwd1),
        .fwd2     (fwd2),
        .count    (count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t sb[$];
    wr_t mon_e;
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one request for one cycle; exp_acc is the hand-derived in_ready.
    task automatic cycle_enq(input logic [4:0] a, input logic [31:0] d, input logic exp_acc);
        wr_t e;
        in_addr  = a;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(exp_acc));
        @(posedge clk);
        if (exp_acc && a != 5'd0) begin
            e.a = a;
            e.d = d;
            sb.push_back(e);
        end
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every write leaving the DUT must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%0h expected no write", wr_addr, wr_data);
            end else begin
                mon_e = sb.pop_front();
                $display("write addr=%0d data=%0h (expected addr=%0d data=%0h)", wr_addr, wr_data, mon_e.a, mon_e.d);
                chk("wr_addr", 32'(wr_addr), 32'(mon_e.a));
                chk("wr_data", wr_data, mon_e.d);
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_addr  = '0;
        in_data  = '0;
        wr_stall = 1'b0;
        inp1     = '0;
        inp2     = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_hit1", 32'(hit1), 0);
        chk("rst_hit2", 32'(hit2), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_fwd1", fwd1, 0);
        step();
        rst = 1'b0;

        // 1: single write, one-cycle latency when empty and unstalled
        cycle_enq(5'd3, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        chk("t1_wr_en", 32'(wr_en), 1);
        chk("t1_wr_addr", 32'(wr_addr), 3);
        chk("t1_wr_data", wr_data, 32'hDEADBEEF);
        step();
        @(negedge clk);
        chk("t1_count", 32'(count), 0);
        chk("t1_wr_en_off", 32'(wr_en), 0);
        step();

        // 2: fill under stall, full blocks a 5th, then in-order drain
        wr_stall = 1'b1;
        for (int k = 1; k <= 4; k++) cycle_enq(5'(k), 32'(k * 32'h11), 1'b1);
        cycle_enq(5'd5, 32'h55, 1'b0);
        @(negedge clk);
        chk("t2_count_full", 32'(count), 4);
        chk("t2_stalled_wr_en", 32'(wr_en), 0);
        chk("t2_head_addr", 32'(wr_addr), 1);
        step();
        wr_stall = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("t2_drain_wr_en", 32'(wr_en), 1);
            chk("t2_drain_addr", 32'(wr_addr), 32'(k));
            step();
        end
        @(negedge clk);
        chk("t2_count_empty", 32'(count), 0);
        step();

        // 3: forwarding, youngest wins, same-cycle enqueue not visible
        wr_stall = 1'b1;
        inp1     = 5'd8;
        inp2     = 5'd15;
        cycle_enq(5'd8, 32'hA, 1'b1);
        @(negedge clk);
        chk("t3_hit1_first", 32'(hit1), 1);
        chk("t3_fwd1_first", fwd1, 32'hA);
        step();
        in_addr  = 5'd8;
        in_data  = 32'hB;
        in_valid = 1'b1;
        @(negedge clk);
        chk("t3_same_cycle_fwd1", fwd1, 32'hA);
        chk("t3_hit2_before", 32'(hit2), 0);
        step();
        in_valid = 1'b0;
        sb.push_back('{a: 5'd8, d: 32'hB});
        cycle_enq(5'd15, 32'hC, 1'b1);
        @(negedge clk);
        chk("t3_hit1", 32'(hit1), 1);
        chk("t3_fwd1", fwd1, 32'hB);
        chk("t3_hit2", 32'(hit2), 1);
        chk("t3_fwd2", fwd2, 32'hC);
        step();
        inp1 = 5'd9;
        @(negedge clk);
        chk("t3_miss_hit1", 32'(hit1), 0);
        chk("t3_miss_fwd1", fwd1, 0);
        step();
        wr_stall = 1'b0;
        inp1     = '0;
        inp2     = '0;
        repeat (4) step();
        @(negedge clk);
        chk("t3_count_empty", 32'(count), 0);
        step();

        // 4: full queue, stall released, in_valid every cycle for 20 cycles
        wr_stall = 1'b1;
        for (int k = 0; k < 4; k++) cycle_enq(5'(16 + k), 32'h400 + 32'(k), 1'b1);
        wr_stall = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle_enq(5'(i + 1), 32'h1000 + 32'(i), (i != 0));
            chk("t4_steady_count", 32'(count), 3);
        end
        repeat (5) step();
        @(negedge clk);
        chk("t4_count_empty", 32'(count), 0);
        chk("t4_sb_drained", 32'(sb.size()), 0);
        step();

        // 5: address 0 handshakes but is dropped
        inp1 = 5'd0;
        cycle_enq(5'd0, 32'h5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_count", 32'(count), 0);
            chk("t5_wr_en", 32'(wr_en), 0);
            chk("t5_hit1", 32'(hit1), 0);
            step();
        end

        // 6: reset with three pending entries discards them
        wr_stall = 1'b1;
        cycle_enq(5'd20, 32'h20, 1'b1);
        cycle_enq(5'd21, 32'h21, 1'b1);
        cycle_enq(5'd22, 32'h22, 1'b1);
        @(negedge clk);
        chk("t6_count_pending", 32'(count), 3);
        step();
        wr_stall = 1'b0;
        rst      = 1'b1;
        sb.delete();
        step();
        rst  = 1'b0;
        inp1 = 5'd20;
        inp2 = 5'd22;
        @(negedge clk);
        chk("t6_count", 32'(count), 0);
        chk("t6_wr_en", 32'(wr_en), 0);
        chk("t6_in_ready", 32'(in_ready), 1);
        chk("t6_hit1", 32'(hit1), 0);
        chk("t6_hit2", 32'(hit2), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            @(negedge clk);
            chk("t6_no_write", 32'(wr_en), 0);
        end
        chk("sb_empty", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
